// File: rtl/gps_nav_msg_gen.sv
// gps_nav_msg_gen: 50 bps GPS navigation-data bit generator for the signal core.
//
// Each nav bit spans EPOCHS_PER_BIT C/A code epochs, and bit edges are aligned to the core's
// epoch pulse. In preset mode a subframe is the 8-bit preamble followed by PRBS9 fill, and the
// PRBS9 generator is reseeded at every subframe start. In external mode each bit comes from a
// pad input through a two-flop synchroniser.
//
// Ports:
//   clk_in          system clock
//   rst_in_n        asynchronous active-low reset
//   ena_in          general enable; low holds the generator in its reset state
//   epoch_in        one-cycle C/A epoch pulse (core start_out)
//   use_preset_in   1 = preamble + PRBS9 pattern, 0 = external pad bit
//   ext_msg_in      asynchronous external nav bit
//   msg_out         current nav bit (to core msg_in)
//   bit_strobe_out  one-cycle pulse when msg_out loads a new bit
//   bit_idx_out     index of the bit currently on msg_out
//   subframe_start_out  (only with NAV_MSG_SYNC_OUT_EN) pulses with the strobe for bit 0
//
// Optional feature macro: NAV_MSG_SYNC_OUT_EN adds subframe_start_out.

module gps_nav_msg_gen #(
    parameter int unsigned EPOCHS_PER_BIT    = 20,
    parameter int unsigned BITS_PER_SUBFRAME = 300,
    parameter logic [7:0]  PREAMBLE          = 8'h8B,
    parameter logic [8:0]  LFSR_SEED         = 9'h1FF
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       ena_in,
    input  logic       epoch_in,
    input  logic       use_preset_in,
    input  logic       ext_msg_in,
    output logic       msg_out,
    output logic       bit_strobe_out,
    output logic [8:0] bit_idx_out
`ifdef NAV_MSG_SYNC_OUT_EN
    ,
    output logic       subframe_start_out
`endif
);

    // A single-epoch bit still needs a 1-bit counter so the widths stay legal.
    localparam int unsigned   CNT_W    = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EPOCHS_PER_BIT - 1);
    localparam logic [8:0]    IDX_LAST = 9'(BITS_PER_SUBFRAME - 1);

    // External bit synchroniser. It keeps running while disabled so the first external bit
    // after enable is already settled.
    logic ext_meta_q;
    logic ext_sync_q;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
        end else begin
            ext_meta_q <= ext_msg_in;
            ext_sync_q <= ext_meta_q;
        end
    end

    // Generator state
    logic [CNT_W-1:0] epoch_cnt_q, epoch_cnt_d;
    logic [8:0]       next_idx_q,  next_idx_d;
    logic [8:0]       lfsr_q,      lfsr_d;
    logic             msg_q,       msg_d;
    logic             strobe_q,    strobe_d;
    logic [8:0]       bit_idx_q,   bit_idx_d;
    logic             load;
    logic             new_bit;

    // A load happens on the first epoch of each bit period.
    assign load = ena_in & epoch_in & (epoch_cnt_q == '0);

    always_comb begin
        epoch_cnt_d = epoch_cnt_q;
        next_idx_d  = next_idx_q;
        lfsr_d      = lfsr_q;
        msg_d       = msg_q;
        bit_idx_d   = bit_idx_q;
        strobe_d    = 1'b0;
        new_bit     = 1'b0;

        if (!ena_in) begin
            // Disabled: restart from bit 0 with a fresh seed.
            epoch_cnt_d = '0;
            next_idx_d  = '0;
            lfsr_d      = LFSR_SEED;
            msg_d       = 1'b0;
            bit_idx_d   = '0;
        end else if (epoch_in) begin
            epoch_cnt_d = (epoch_cnt_q == CNT_LAST) ? '0 : epoch_cnt_q + CNT_W'(1);

            if (load) begin
                if (use_preset_in) begin
                    if (next_idx_q < 9'd8) begin
                        new_bit = PREAMBLE[3'd7 - next_idx_q[2:0]];
                    end else begin
                        new_bit = lfsr_q[8];
                        lfsr_d  = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
                    end
                end else begin
                    // External mode leaves the PRBS state untouched.
                    new_bit = ext_sync_q;
                end

                msg_d     = new_bit;
                bit_idx_d = next_idx_q;
                strobe_d  = 1'b1;

                if (next_idx_q == IDX_LAST) begin
                    next_idx_d = '0;
                    lfsr_d     = LFSR_SEED;
                end else begin
                    next_idx_d = next_idx_q + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            epoch_cnt_q <= '0;
            next_idx_q  <= '0;
            lfsr_q      <= LFSR_SEED;
            msg_q       <= 1'b0;
            strobe_q    <= 1'b0;
            bit_idx_q   <= '0;
        end else begin
            epoch_cnt_q <= epoch_cnt_d;
            next_idx_q  <= next_idx_d;
            lfsr_q      <= lfsr_d;
            msg_q       <= msg_d;
            strobe_q    <= strobe_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

    assign msg_out        = msg_q;
    assign bit_strobe_out = strobe_q;
    assign bit_idx_out    = bit_idx_q;

`ifdef NAV_MSG_SYNC_OUT_EN
    logic sub_start_q;
    logic sub_start_d;

    assign sub_start_d = load & (next_idx_q == '0);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sub_start_q <= 1'b0;
        end else begin
            sub_start_q <= sub_start_d;
        end
    end

    assign subframe_start_out = sub_start_q;
`endif

endmodule

// File: tb/tb_gps_nav_msg_gen.sv
// Directed bench for gps_nav_msg_gen. A second instance built with EPOCHS_PER_BIT=1 shares the
// stimulus and is checked during the preset run.
module tb_gps_nav_msg_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       epoch;
    logic       use_preset;
    logic       ext;
    logic       msg;
    logic       stb;
    logic [8:0] idx_o;
    logic       msg1;
    logic       stb1;
    logic [8:0] idx1;
`ifdef NAV_MSG_SYNC_OUT_EN
    logic       sub;
    logic       sub1;
`endif

    gps_nav_msg_gen u_dut (
        .clk_in         (clk),
        .rst_in_n       (rst_n),
        .ena_in         (ena),
        .epoch_in       (epoch),
        .use_preset_in  (use_preset),
        .ext_msg_in     (ext),
        .msg_out        (msg),
        .bit_strobe_out (stb),
        .bit_idx_out    (idx_o)
`ifdef NAV_MSG_SYNC_OUT_EN
        ,
        .subframe_start_out (sub)
`endif
    );

    gps_nav_msg_gen #(
        .EPOCHS_PER_BIT (1)
    ) u_dut1 (
        .clk_in         (clk),
        .rst_in_n       (rst_n),
        .ena_in         (ena),
        .epoch_in       (epoch),
        .use_preset_in  (use_preset),
        .ext_msg_in     (ext),
        .msg_out        (msg1),
        .bit_strobe_out (stb1),
        .bit_idx_out    (idx1)
`ifdef NAV_MSG_SYNC_OUT_EN
        ,
        .subframe_start_out (sub1)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cnt  = 0;
    int strobe1_cnt = 0;
    int ep_cnt      = 0;
    int c0;
    int c1;
    logic       rec_en = 1'b0;
    logic       rec1 [0:31];
    logic [0:23] exp_bits;

    logic       ld_msg;
    logic [8:0] ld_idx;
    logic       ld_stb;
    logic       ld_sub;

    always @(negedge clk) begin
        if (stb)  strobe_cnt++;
        if (stb1) strobe1_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle epoch pulse; returns on the falling edge right after the epoch edge.
    task automatic pulse();
        @(negedge clk);
        epoch = 1'b1;
        @(negedge clk);
        epoch = 1'b0;
        if (rec_en && ep_cnt < 32) rec1[ep_cnt] = msg1;
        ep_cnt++;
    endtask

    task automatic rest_epochs(input int n);
        for (int e = 0; e < n; e++) begin
            pulse();
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic load_bit();
        pulse();
        ld_msg = msg;
        ld_idx = idx_o;
        ld_stb = stb;
`ifdef NAV_MSG_SYNC_OUT_EN
        ld_sub = sub;
`else
        ld_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_load(input string tag, input logic eb, input int ei);
        load_bit();
        check_eq($sformatf("%s_bit%0d", tag, ei), {31'd0, ld_msg}, {31'd0, eb});
        check_eq($sformatf("%s_idx%0d", tag, ei), {23'd0, ld_idx}, ei);
        check_eq($sformatf("%s_stb%0d", tag, ei), {31'd0, ld_stb}, 32'd1);
`ifdef NAV_MSG_SYNC_OUT_EN
        check_eq($sformatf("%s_sub%0d", tag, ei), {31'd0, ld_sub}, (ei == 0) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        // preamble 8B, nine seed ones, then PRBS9 continues 0,0,0,0,0,1,1
        exp_bits = {8'b1000_1011, 9'b1_1111_1111, 5'b0_0000, 2'b11};
        rst_n      = 1'b0;
        ena        = 1'b0;
        epoch      = 1'b0;
        use_preset = 1'b1;
        ext        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_msg", {31'd0, msg}, 32'd0);
        check_eq("rst_stb", {31'd0, stb}, 32'd0);
        check_eq("rst_idx", {23'd0, idx_o}, 32'd0);
        check_eq("rst_idx1", {23'd0, idx1}, 32'd0);
`ifdef NAV_MSG_SYNC_OUT_EN
        check_eq("rst_sub", {31'd0, sub}, 32'd0);
        check_eq("rst_sub1", {31'd0, sub1}, 32'd0);
`endif

        // Idle: enable low, epochs ignored
        rst_n = 1'b1;
        rest_epochs(50);
        check_eq("idle_stb_cnt", strobe_cnt, 32'd0);
        check_eq("idle_stb1_cnt", strobe1_cnt, 32'd0);
        check_eq("idle_msg", {31'd0, msg}, 32'd0);
        check_eq("idle_idx", {23'd0, idx_o}, 32'd0);

        // Preset preamble + PRBS9
        ena = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("pre_wait_msg", {31'd0, msg}, 32'd0);
        c0 = strobe_cnt;
        c1 = strobe1_cnt;
        ep_cnt = 0;
        rec_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            chk_load("pre", exp_bits[i], i);
            rest_epochs(19);
        end
        rec_en = 1'b0;
        check_eq("stb_per_bit", strobe_cnt - c0, 32'd24);
        check_eq("epb1_stb_cnt", strobe1_cnt - c1, 32'd480);
        for (int i = 0; i < 24; i++) begin
            check_eq($sformatf("epb1_bit%0d", i), {31'd0, rec1[i]}, {31'd0, exp_bits[i]});
        end

        // Finish the subframe and check the wrap
        for (int i = 24; i < 300; i++) begin
            load_bit();
            rest_epochs(19);
        end
        check_eq("last_idx", {23'd0, ld_idx}, 32'd299);
        for (int i = 0; i < 18; i++) begin
            chk_load("sf2", exp_bits[i], i);
            rest_epochs(19);
        end

        // Run to bit 40, then abort mid-bit
        for (int i = 18; i < 41; i++) begin
            load_bit();
            if (i < 40) rest_epochs(19);
        end
        check_eq("b40_idx", {23'd0, ld_idx}, 32'd40);
        rest_epochs(5);
        ena = 1'b0;
        c0 = strobe_cnt;
        rest_epochs(2);
        check_eq("abort_msg", {31'd0, msg}, 32'd0);
        check_eq("abort_idx", {23'd0, idx_o}, 32'd0);
        check_eq("abort_stb_cnt", strobe_cnt - c0, 32'd0);
        ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_load("reen", exp_bits[i], i);
            rest_epochs(19);
        end

        // Mode switch mid-bit 5: takes effect at bit 6
        chk_load("sw", 1'b0, 5);
        rest_epochs(7);
        use_preset = 1'b0;
        ext        = 1'b0;
        rest_epochs(12);
        chk_load("ext", 1'b0, 6);
        ext = 1'b1;
        rest_epochs(19);
        check_eq("ext_hold_msg", {31'd0, msg}, 32'd0);
        chk_load("ext", 1'b1, 7);
        rest_epochs(10);
        ext = 1'b0;
        rest_epochs(9);
        // Too late to pass the synchroniser before this load
        @(negedge clk);
        ext = 1'b1;
        chk_load("ext_late", 1'b0, 8);
        rest_epochs(9);
        use_preset = 1'b1;
        rest_epochs(10);
        // PRBS state was held through the external bit, so the seed resumes at bit 9
        for (int i = 9; i < 19; i++) begin
            chk_load("resume", (i < 18) ? 1'b1 : 1'b0, i);
            rest_epochs(19);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
